// File: rtl/zapper_flash_seq.sv
// zapper_flash_seq
// Display-side responder for the light-gun hit test. A shot pulse arms the
// sequence: one black frame, then WHITE_FRAMES frames with only the target
// box drawn white. Synchronized photodiode detect cycles are counted in each
// phase. Light during the black frame forces a miss, because the gun is then
// aimed at a lamp rather than the screen. Otherwise the shot is a hit when
// enough light is seen while the target is white. Shot and hit tallies are
// kept for the CPU.
//
// Ports:
//   clk          system clock
//   reset_n      synchronous active-low reset
//   pulse        one-cycle shot request
//   frame_start  one-cycle pulse at the start of each video frame
//   detect       raw photodiode input (asynchronous, 1 = light)
//   clr_counts   one-cycle request to zero shot_count and hit_count
//   busy         sequence in progress (state != IDLE)
//   blank_screen force black on all pixels (registered)
//   draw_target  force white inside the target box (registered)
//   hit / miss   one-cycle result strobes
//   shot_count   resolved shots, saturating at 255
//   hit_count    hits, saturating at 255
module zapper_flash_seq #(
   parameter int WHITE_FRAMES    = 1,
   parameter int DETECT_MIN      = 4,
   parameter int COOLDOWN_FRAMES = 2,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pulse,
   input  logic       frame_start,
   input  logic       detect,
   input  logic       clr_counts,
   output logic       busy,
   output logic       blank_screen,
   output logic       draw_target,
   output logic       hit,
   output logic       miss,
   output logic [7:0] shot_count,
   output logic [7:0] hit_count
);

   typedef enum logic [2:0] {IDLE, ARM, BLACK, WHITE, RESULT, COOLDOWN} state_t;

   localparam logic [CNT_W-1:0] DET_MIN    = CNT_W'(DETECT_MIN);
   localparam logic [7:0]       WHITE_LAST = 8'(WHITE_FRAMES - 1);
   localparam logic [7:0]       COOL_LAST  = 8'(COOLDOWN_FRAMES - 1);

   state_t           state, state_next;
   logic             det_s1, det_s2;
   logic [CNT_W-1:0] det_cnt, det_cnt_next, det_cnt_inc;
   logic [7:0]       frame_cnt, frame_cnt_next;
   logic             black_lit, black_lit_next;
   logic             hit_next, miss_next;

   // Saturating increment; includes the current cycle's sample, so the
   // frame_start cycle itself still counts toward the closing frame.
   assign det_cnt_inc = (det_s2 && (det_cnt != '1)) ? det_cnt + 1'b1 : det_cnt;

   assign busy = (state != IDLE);

   always_comb begin
      state_next     = state;
      det_cnt_next   = det_cnt;
      frame_cnt_next = frame_cnt;
      black_lit_next = black_lit;
      hit_next       = 1'b0;
      miss_next      = 1'b0;
      case (state)
         IDLE: begin
            det_cnt_next = '0;
            if (pulse) state_next = ARM;
         end
         ARM: begin
            det_cnt_next = '0;
            if (frame_start) state_next = BLACK;
         end
         BLACK: begin
            det_cnt_next = det_cnt_inc;
            if (frame_start) begin
               black_lit_next = (det_cnt_inc >= DET_MIN);
               det_cnt_next   = '0;
               frame_cnt_next = '0;
               state_next     = WHITE;
            end
         end
         WHITE: begin
            det_cnt_next = det_cnt_inc;
            if (frame_start) begin
               if (frame_cnt == WHITE_LAST) begin
                  // Result is decided on the closing edge so the strobe is
                  // visible during the single RESULT cycle.
                  state_next = RESULT;
                  hit_next   = !black_lit && (det_cnt_inc >= DET_MIN);
                  miss_next  = !hit_next;
               end else begin
                  frame_cnt_next = frame_cnt + 1'b1;
               end
            end
         end
         RESULT: begin
            frame_cnt_next = '0;
            state_next     = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
         end
         COOLDOWN: begin
            if (frame_start) begin
               if (frame_cnt == COOL_LAST) state_next = IDLE;
               else frame_cnt_next = frame_cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         det_s1       <= 1'b0;
         det_s2       <= 1'b0;
         det_cnt      <= '0;
         frame_cnt    <= '0;
         black_lit    <= 1'b0;
         hit          <= 1'b0;
         miss         <= 1'b0;
         blank_screen <= 1'b0;
         draw_target  <= 1'b0;
         shot_count   <= '0;
         hit_count    <= '0;
      end else begin
         state        <= state_next;
         det_s1       <= detect;
         det_s2       <= det_s1;
         det_cnt      <= det_cnt_next;
         frame_cnt    <= frame_cnt_next;
         black_lit    <= black_lit_next;
         hit          <= hit_next;
         miss         <= miss_next;
         blank_screen <= (state == BLACK) || (state == WHITE);
         draw_target  <= (state == WHITE);
         if (clr_counts) begin
            shot_count <= '0;
            hit_count  <= '0;
         end else if (hit_next || miss_next) begin
            if (shot_count != '1) shot_count <= shot_count + 1'b1;
            if (hit_next && (hit_count != '1)) hit_count <= hit_count + 1'b1;
         end
      end
   end

endmodule
